// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the fetch/data port arbiter.
// master = arbiter (issues requests), slave = memory (acks and returns data).
interface mem_port_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access; data has priority.
// Optional MISALIGN_TRAP_EN: misaligned data accesses complete without a memory cycle and flag dm_misalign.
//
// state | meaning
// IDLE  | no transaction; sample data request first, then fetch
// BUSY  | mem_req held with latched command until mem_ack
// RESP  | one-cycle done pulse to the owner, rdata valid
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_load_type,
  input  logic [1:0]  dm_store_type,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic        dm_misalign,
`endif
  output logic        stall_if,
  output logic        stall_mem,
  mem_port_arbiter_if.master mem
);

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_nxt;
  logic        start_data, start_fetch, capture, trap, misalign_now;
  logic        owner_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q, if_rdata_q, dm_rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  ltype_q;
  logic [1:0]  off_q;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        dm_any;

  assign dm_any = dm_read | dm_write;

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] t,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {off, 3'b000});
    h = off[1] ? d[31:16] : d[15:0];
    case (t)
      LD_LB:   load_ext = {{24{b[7]}}, b};
      LD_LH:   load_ext = {{16{h[15]}}, h};
      LD_LBU:  load_ext = {24'b0, b};
      LD_LHU:  load_ext = {16'b0, h};
      default: load_ext = d;
    endcase
  endfunction

  always_comb begin
    st_be   = 4'b1111;
    st_data = dm_wdata;
    case (dm_store_type)
      ST_SB: begin
        st_be   = 4'b0001 << dm_addr[1:0];
        st_data = {4{dm_wdata[7:0]}};
      end
      ST_SH: begin
        st_be   = dm_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{dm_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Write wins when both strobes are high, so its type decides alignment.
  always_comb begin
    misalign_now = 1'b0;
    if (dm_write) begin
      case (dm_store_type)
        ST_SB:   misalign_now = 1'b0;
        ST_SH:   misalign_now = dm_addr[0];
        default: misalign_now = |dm_addr[1:0];
      endcase
    end else begin
      case (dm_load_type)
        LD_LH, LD_LHU: misalign_now = dm_addr[0];
        LD_LW:         misalign_now = |dm_addr[1:0];
        default:       misalign_now = 1'b0;
      endcase
    end
  end
`else
  assign misalign_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_q;
    start_data  = 1'b0;
    start_fetch = 1'b0;
    capture     = 1'b0;
    trap        = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_any) begin
          start_data = 1'b1;
          trap       = misalign_now;
          state_nxt  = misalign_now ? RESP : BUSY;
        end else if (if_req) begin
          start_fetch = 1'b1;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (mem.mem_ack) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      ltype_q    <= '0;
      off_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (start_data) begin
        owner_q <= 1'b1;
        we_q    <= dm_write;
        addr_q  <= dm_addr & 32'hFFFF_FFFC;
        be_q    <= dm_write ? st_be : 4'b1111;
        wdata_q <= st_data;
        ltype_q <= dm_load_type;
        off_q   <= dm_addr[1:0];
      end else if (start_fetch) begin
        owner_q <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= if_addr & 32'hFFFF_FFFC;
        be_q    <= 4'b1111;
      end
      // Stores leave dm_rdata untouched so the last load value stays visible.
      if (capture) begin
        if (!owner_q)   if_rdata_q <= mem.mem_rdata;
        else if (!we_q) dm_rdata_q <= load_ext(mem.mem_rdata, ltype_q, off_q);
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          misalign_q <= 1'b0;
    else if (start_data) misalign_q <= trap;
  end
  assign dm_misalign = dm_done & misalign_q;
`endif

  assign mem.mem_req   = (state_q == BUSY);
  assign mem.mem_we    = (state_q == BUSY) & we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  assign if_done   = (state_q == RESP) & ~owner_q;
  assign dm_done   = (state_q == RESP) & owner_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = dm_any & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected bus commands and responses are queued at
// stimulus time and popped by a negedge monitor. Honours MISALIGN_TRAP_EN when defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_read = 1'b0;
  logic        dm_write = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [2:0]  dm_load_type = '0;
  logic [1:0]  dm_store_type = '0;
  logic        dm_done;
  logic [31:0] dm_rdata;
`ifdef MISALIGN_TRAP_EN
  logic        dm_misalign;
`endif
  logic        stall_if, stall_mem;

  always #5 clk = ~clk;

  mem_port_arbiter_if mem ();

  mem_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_done       (if_done),
    .if_rdata      (if_rdata),
    .dm_read       (dm_read),
    .dm_write      (dm_write),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_load_type  (dm_load_type),
    .dm_store_type (dm_store_type),
    .dm_done       (dm_done),
    .dm_rdata      (dm_rdata),
`ifdef MISALIGN_TRAP_EN
    .dm_misalign   (dm_misalign),
`endif
    .stall_if      (stall_if),
    .stall_mem     (stall_mem),
    .mem           (mem.master)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
    logic        mis;
  } rsp_t;

  bus_t        bus_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mdat_q[$];
  bus_t        cur_bus;
  rsp_t        mon_r;
  bit          req_open = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          ack_dly = 0;
  int          resp_cnt = 0;
  bit          spur = 1'b0;
  logic [31:0] last_dm = '0;
  int          n;
  logic [31:0] erd_d, erd_f;
  bit          mis_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory model: ack ack_dly cycles after mem_req rises; optional spurious ack while idle.
  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem.mem_req) begin
        if (resp_cnt >= ack_dly) begin
          mem.mem_ack   = 1'b1;
          mem.mem_rdata = (mdat_q.size() > 0) ? mdat_q.pop_front() : 32'hBAD0_BAD0;
          resp_cnt      = 0;
        end else begin
          mem.mem_ack = 1'b0;
          resp_cnt++;
        end
      end else begin
        mem.mem_ack = spur;
        resp_cnt    = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem.mem_req) begin
      if (!req_open) begin
        req_open = 1'b1;
        if (bus_q.size() == 0) begin
          chk("unexp_req", 32'(mem.mem_req), 32'd0);
          cur_bus = '0;
        end else cur_bus = bus_q.pop_front();
      end
      chk("mem_we", 32'(mem.mem_we), 32'(cur_bus.we));
      chk("mem_addr", mem.mem_addr, cur_bus.addr);
      chk("mem_be", 32'(mem.mem_be), 32'(cur_bus.be));
      if (cur_bus.we) chk("mem_wdata", mem.mem_wdata, cur_bus.wdata);
    end else req_open = 1'b0;
    if (if_done) begin
      if (rsp_q.size() == 0 || rsp_q[0].is_data) chk("unexp_if_done", 32'(if_done), 32'd0);
      else begin
        mon_r = rsp_q.pop_front();
        chk("if_rdata", if_rdata, mon_r.rdata);
      end
    end
    if (dm_done) begin
      if (rsp_q.size() == 0 || !rsp_q[0].is_data) chk("unexp_dm_done", 32'(dm_done), 32'd0);
      else begin
        mon_r = rsp_q.pop_front();
        chk("dm_rdata", dm_rdata, mon_r.rdata);
`ifdef MISALIGN_TRAP_EN
        chk("dm_misalign", 32'(dm_misalign), 32'(mon_r.mis));
`endif
      end
    end
  end

  task automatic wait_done(input bit want_data, input bit watch_if, output int cnt);
    bit got;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (want_data ? dm_done : if_done) got = 1'b1;
      else if (want_data) chk("stall_mem", 32'(stall_mem), 32'd1);
      else chk("stall_if", 32'(stall_if), 32'd1);
      if (watch_if) chk("stall_if_held", 32'(stall_if), 32'd1);
    end
    if (!got) chk("done_timeout", 32'(want_data ? dm_done : if_done), 32'd1);
    else if (want_data) chk("stall_mem_done", 32'(stall_mem), 32'd0);
    else chk("stall_if_done", 32'(stall_if), 32'd0);
  endtask

  task automatic fetch_push(input logic [31:0] addr, input logic [31:0] rd);
    bus_q.push_back('{1'b0, addr & 32'hFFFF_FFFC, 4'hF, 32'h0});
    rsp_q.push_back('{1'b1 ^ 1'b1, rd, 1'b0});
    mdat_q.push_back(rd);
  endtask

  task automatic data_push(input logic rd, input logic wr, input logic [2:0] lt,
                           input logic [1:0] st, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] mrd,
                           output logic [31:0] erd, output bit mis);
    logic [3:0]  be;
    logic [31:0] ewd, lv;
    logic [7:0]  b;
    logic [15:0] h;
    be  = 4'hF;
    ewd = 32'h0;
    if (wr) begin
      case (st)
        2'b00: begin
          be  = 4'(1 << addr[1:0]);
          ewd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end
        2'b01: begin
          be  = addr[1] ? 4'b1100 : 4'b0011;
          ewd = {wd[15:0], wd[15:0]};
        end
        default: ewd = wd;
      endcase
    end
    case (addr[1:0])
      2'd0:    b = mrd[7:0];
      2'd1:    b = mrd[15:8];
      2'd2:    b = mrd[23:16];
      default: b = mrd[31:24];
    endcase
    h = addr[1] ? mrd[31:16] : mrd[15:0];
    case (lt)
      3'b000:  lv = {{24{b[7]}}, b};
      3'b001:  lv = {{16{h[15]}}, h};
      3'b011:  lv = {24'h0, b};
      3'b100:  lv = {16'h0, h};
      default: lv = mrd;
    endcase
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (wr) mis = (st == 2'b01) ? addr[0] : (st == 2'b10) ? (addr[1:0] != 2'b00) : 1'b0;
    else    mis = (lt == 3'b001 || lt == 3'b100) ? addr[0] :
                  (lt == 3'b010) ? (addr[1:0] != 2'b00) : 1'b0;
`endif
    erd = (wr || mis) ? last_dm : lv;
    if (!mis) begin
      bus_q.push_back('{wr, addr & 32'hFFFF_FFFC, be, ewd});
      mdat_q.push_back(mrd);
    end
    rsp_q.push_back('{1'b1, erd, mis});
    last_dm = erd;
    if (rd !== 1'b1 && wr !== 1'b1) chk("data_push_no_strobe", 32'(rd | wr), 32'd1);
  endtask

  task automatic data_txn(input logic rd, input logic wr, input logic [2:0] lt,
                          input logic [1:0] st, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] mrd, input int dly);
    logic [31:0] erd;
    bit          mis;
    int          cnt;
    ack_dly = dly;
    data_push(rd, wr, lt, st, addr, wd, mrd, erd, mis);
    @(posedge clk);
    #1;
    dm_read = rd; dm_write = wr; dm_load_type = lt; dm_store_type = st;
    dm_addr = addr; dm_wdata = wd;
    wait_done(1'b1, 1'b0, cnt);
    chk("dm_latency", cnt, mis ? 32'd2 : 32'(3 + dly));
    dm_read = 1'b0; dm_write = 1'b0;
  endtask

  task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] rd, input int dly);
    int cnt;
    ack_dly = dly;
    fetch_push(addr, rd);
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = addr;
    wait_done(1'b0, 1'b0, cnt);
    chk("if_latency", cnt, 32'(3 + dly));
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem.mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem.mem_be), 32'd0);
    chk("rst_mem_addr", mem.mem_addr, 32'd0);
    chk("rst_mem_wdata", mem.mem_wdata, 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_dm_done", 32'(dm_done), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fetch_txn(32'h0000_0100, 32'h0050_0093, 0);

    // Simultaneous fetch and load: data first, fetch after dm_done, stall_if held throughout.
    ack_dly = 0;
    data_push(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_0300, 32'h0, 32'h1122_3344, erd_d, mis_d);
    fetch_push(32'h0000_0104, 32'h0010_0113);
    erd_f = 32'h0010_0113;
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h0000_0104;
    dm_read = 1'b1; dm_load_type = 3'b010; dm_addr = 32'h0000_0300;
    wait_done(1'b1, 1'b1, n);
    chk("conc_dm_latency", n, 32'd3);
    chk("conc_no_req_in_resp", 32'(mem.mem_req), 32'd0);
    dm_read = 1'b0;
    wait_done(1'b0, 1'b0, n);
    chk("conc_if_latency", n, 32'd3);
    chk("conc_if_rdata", if_rdata, erd_f);
    if_req = 1'b0;

    data_txn(1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_0203, 32'h0000_00AB, 32'hDEAD_BEEF, 0);
    data_txn(1'b0, 1'b1, 3'b000, 2'b01, 32'h0000_0102, 32'h1234_5678, 32'h0, 1);
    data_txn(1'b0, 1'b1, 3'b000, 2'b01, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 0);
    data_txn(1'b0, 1'b1, 3'b000, 2'b10, 32'h0000_0107, 32'h8765_4321, 32'h0, 2);
    data_txn(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_0201, 32'h0, 32'h0000_8000, 0);
    data_txn(1'b1, 1'b0, 3'b011, 2'b00, 32'h0000_0201, 32'h0, 32'h0000_8000, 0);
    data_txn(1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_0202, 32'h0, 32'h8001_0000, 1);
    data_txn(1'b1, 1'b0, 3'b100, 2'b00, 32'h0000_0202, 32'h0, 32'h8001_0000, 0);
    data_txn(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_0102, 32'h0, 32'h5555_AAAA, 0);
    data_txn(1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_0201, 32'h0, 32'h00FF_7F00, 0);
    data_txn(1'b1, 1'b1, 3'b010, 2'b10, 32'h0000_0400, 32'h0BAD_CAFE, 32'h1357_9BDF, 0);
    data_txn(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_0404, 32'h0, 32'h2468_ACE0, 3);
    fetch_txn(32'h0000_0108, 32'h0000_0013, 3);

    // Ack while idle must not start or complete anything.
    spur = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("spur_mem_req", 32'(mem.mem_req), 32'd0);
      chk("spur_dm_done", 32'(dm_done), 32'd0);
      chk("spur_if_done", 32'(if_done), 32'd0);
    end
    spur = 1'b0;

    // Reset while an ack is pending: request drops immediately, no done ever.
    ack_dly = 6;
    bus_q.push_back('{1'b0, 32'h0000_0500, 4'hF, 32'h0});
    mdat_q.push_back(32'h7777_7777);
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h0000_0500;
    n = 0;
    while (!mem.mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_busy_reached", 32'(mem.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst_async_mem_addr", mem.mem_addr, 32'd0);
    chk("rst_async_mem_be", 32'(mem.mem_be), 32'd0);
    if_req = 1'b0;
    mdat_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_dm = '0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_mem_req", 32'(mem.mem_req), 32'd0);
      chk("post_rst_if_done", 32'(if_done), 32'd0);
    end
    chk("post_rst_if_rdata", if_rdata, 32'd0);
    chk("post_rst_dm_rdata", dm_rdata, 32'd0);

    fetch_txn(32'h0000_0500, 32'h00A0_0513, 0);
    data_txn(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_0600, 32'h0, 32'h0000_00F0, 0);

    repeat (3) @(negedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
